// File: rtl/sha1_block_engine.sv
// SHA-1 block compression engine, driven by an external state controller.
//
// The 2-bit command on state_in selects what the engine does:
//   00/11  clear H and go idle
//   01     load the SHA-1 initial hash constants and go idle
//   10     compute: accept 16 big-endian words, run 80 rounds, accumulate into H
// Any non-compute command aborts an in-flight block, and no done pulse is produced.
//
// Ports:
//   clk           rising-edge clock
//   nreset        synchronous, active-low reset
//   state_in      controller command (see above)
//   msg_word      message word, word 0 of the block first
//   msg_valid     msg_word is valid this cycle
//   msg_ready     engine accepts msg_word this cycle
//   busy          high while rounds or the final H update are in progress
//   done          one-cycle pulse after H has been updated with a block
//   digest        {H0,H1,H2,H3,H4}, driven straight from the H registers
//   digest_valid  digest holds a completed result
module sha1_block_engine #(
  parameter int unsigned NUM_ROUNDS      = 80,
  parameter int unsigned WORDS_PER_BLOCK = 16
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [1:0]   state_in,
  input  logic [31:0]  msg_word,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic         busy,
  output logic         done,
  output logic [159:0] digest,
  output logic         digest_valid
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StRound  = 2'd2;
  localparam logic [1:0] StUpdate = 2'd3;

  localparam logic [1:0] CmdInit    = 2'b01;
  localparam logic [1:0] CmdCompute = 2'b10;

  localparam logic [6:0] LastRound = 7'(NUM_ROUNDS - 1);
  localparam logic [3:0] LastWord  = 4'(WORDS_PER_BLOCK - 1);

  localparam logic [31:0] HInit [5] = '{
    32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
  };

  logic [1:0]  state_q, state_d;
  logic [31:0] h_q [5];
  logic [31:0] h_d [5];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] a_q, b_q, c_q, d_q, e_q;
  logic [31:0] a_d, b_d, c_d, d_d, e_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic [6:0]  round_q, round_d;
  logic        done_q, done_d;
  logic        dval_q, dval_d;

  logic        accept;
  logic [3:0]  t_lo, idx_m3, idx_m8, idx_m14;
  logic [31:0] w_mix, w_t, f, k, temp;

  // Only offer ready while the controller is actually asking for compute, so a
  // handshake can never coincide with an abort command.
  assign msg_ready    = (state_q == StLoad) && (state_in == CmdCompute);
  assign accept       = msg_valid && msg_ready;
  assign busy         = (state_q == StRound) || (state_q == StUpdate);
  assign done         = done_q;
  assign digest_valid = dval_q;
  assign digest       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};

  // Message schedule over a 16-entry circular buffer: slot t mod 16 holds
  // W[t-16] when round t starts, and the other taps sit at fixed offsets.
  assign t_lo    = round_q[3:0];
  assign idx_m3  = t_lo + 4'd13;
  assign idx_m8  = t_lo + 4'd8;
  assign idx_m14 = t_lo + 4'd2;
  assign w_mix   = w_q[idx_m3] ^ w_q[idx_m8] ^ w_q[idx_m14] ^ w_q[t_lo];
  assign w_t     = (round_q < 7'd16) ? w_q[t_lo] : {w_mix[30:0], w_mix[31]};

  always_comb begin
    if (round_q < 7'd20) begin
      f = (b_q & c_q) | (~b_q & d_q);
      k = 32'h5A827999;
    end else if (round_q < 7'd40) begin
      f = b_q ^ c_q ^ d_q;
      k = 32'h6ED9EBA1;
    end else if (round_q < 7'd60) begin
      f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
      k = 32'h8F1BBCDC;
    end else begin
      f = b_q ^ c_q ^ d_q;
      k = 32'hCA62C1D6;
    end
  end

  assign temp = {a_q[26:0], a_q[31:27]} + f + e_q + k + w_t;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    round_d    = round_q;
    for (int i = 0; i < 5; i++) h_d[i] = h_q[i];
    for (int i = 0; i < 16; i++) w_d[i] = w_q[i];
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    d_d    = d_q;
    e_d    = e_q;
    done_d = 1'b0;
    dval_d = dval_q;

    case (state_in)
      CmdInit: begin
        for (int i = 0; i < 5; i++) h_d[i] = HInit[i];
        state_d    = StIdle;
        word_cnt_d = '0;
        round_d    = '0;
        dval_d     = 1'b0;
      end
      CmdCompute: begin
        unique case (state_q)
          StIdle: state_d = StLoad;
          StLoad: begin
            if (accept) begin
              w_d[word_cnt_q] = msg_word;
              word_cnt_d      = word_cnt_q + 4'd1;
              if (word_cnt_q == 4'd0) dval_d = 1'b0;
              if (word_cnt_q == LastWord) begin
                a_d     = h_q[0];
                b_d     = h_q[1];
                c_d     = h_q[2];
                d_d     = h_q[3];
                e_d     = h_q[4];
                round_d = '0;
                state_d = StRound;
              end
            end
          end
          StRound: begin
            e_d = d_q;
            d_d = c_q;
            c_d = {b_q[1:0], b_q[31:2]};
            b_d = a_q;
            a_d = temp;
            if (round_q >= 7'd16) w_d[t_lo] = w_t;
            if (round_q == LastRound) begin
              round_d = '0;
              state_d = StUpdate;
            end else begin
              round_d = round_q + 7'd1;
            end
          end
          StUpdate: begin
            h_d[0]     = h_q[0] + a_q;
            h_d[1]     = h_q[1] + b_q;
            h_d[2]     = h_q[2] + c_q;
            h_d[3]     = h_q[3] + d_q;
            h_d[4]     = h_q[4] + e_q;
            done_d     = 1'b1;
            dval_d     = 1'b1;
            word_cnt_d = '0;
            state_d    = StLoad;
          end
        endcase
      end
      default: begin
        for (int i = 0; i < 5; i++) h_d[i] = '0;
        state_d    = StIdle;
        word_cnt_d = '0;
        round_d    = '0;
        dval_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      round_q    <= '0;
      for (int i = 0; i < 5; i++) h_q[i] <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      e_q        <= '0;
      done_q     <= 1'b0;
      dval_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      round_q    <= round_d;
      for (int i = 0; i < 5; i++) h_q[i] <= h_d[i];
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      e_q        <= e_d;
      done_q     <= done_d;
      dval_q     <= dval_d;
    end
  end

endmodule

// File: tb/tb_sha1_block_engine.sv
// Self-checking bench for sha1_block_engine: known-answer vectors, a behavioural
// SHA-1 model feeding an expected-digest queue, latency, abort and clear commands.
module tb_sha1_block_engine;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic [1:0]   state_in = 2'b00;
  logic [31:0]  msg_word = '0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic         busy;
  logic         done;
  logic [159:0] digest;
  logic         digest_valid;

  sha1_block_engine #(
    .NUM_ROUNDS      (80),
    .WORDS_PER_BLOCK (16)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .state_in     (state_in),
    .msg_word     (msg_word),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .busy         (busy),
    .done         (done),
    .digest       (digest),
    .digest_valid (digest_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  localparam logic [159:0] HInit  = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] Abc    = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] Empty  = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] TwoBlk = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  logic [31:0]  blk [16];
  logic [159:0] exp_q [$];
  logic [159:0] exp_d;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Straightforward reference: full 80-entry schedule, one block, returns new H.
  function automatic logic [159:0] sha1_model(input logic [159:0] hin);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 80; t++) w[t] = rotl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rotl(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rotl(b, 30); b = a; a = tmp;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_cmd(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      state_in  = c;
      msg_valid = 1'b0;
    end
  endtask

  // Offers blk[first..last]; e0 is the cycle count seen after word 15's accepting edge.
  task automatic send_words(input int first, input int last, input int gap_pct,
                            output int e0, output bit ok);
    int i;
    int guard;
    i = first;
    guard = 0;
    e0 = 0;
    while (i <= last && guard < 500) begin
      @(negedge clk);
      guard++;
      if (int'($urandom_range(99)) < gap_pct) begin
        msg_valid = 1'b0;
        msg_word  = $urandom;
      end else begin
        msg_valid = 1'b1;
        msg_word  = blk[i];
      end
      #1;
      if (msg_valid && msg_ready) begin
        if (i == 15) e0 = cyc + 1;
        i++;
      end
    end
    ok = (i > last);
  endtask

  // Waits (bounded) for done; optionally offers junk words while the block runs.
  task automatic wait_done(input int e0, input bit junk, output int lat, output int ndone,
                           output int junk_taken);
    lat = -1;
    ndone = 0;
    junk_taken = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - e0;
        ndone++;
        msg_valid = 1'b0;
        break;
      end
      msg_valid = junk;
      msg_word  = $urandom;
      #1;
      if (msg_valid && msg_ready) junk_taken++;
    end
    msg_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; state_in = 2'b10; msg_valid = 1'b1; msg_word = 32'hdeadbeef;
    repeat (3) @(negedge clk);
    checks++; if (digest !== '0) begin failures++; $display("FAIL reset_digest got=%h exp=0", digest); end
    checks++; if (msg_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", msg_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL reset_dval got=%b exp=0", digest_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    nreset = 1'b1; state_in = 2'b00; msg_valid = 1'b0;
  endtask

  task automatic test_init();
    set_cmd(2'b01, 1);
    @(negedge clk);
    checks++; if (digest !== HInit) begin failures++; $display("FAIL init_digest got=%h exp=%h", digest, HInit); end
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL init_dval got=%b exp=0", digest_valid); end
  endtask

  task automatic test_abc();
    int e0, lat, nd, jt;
    bit ok;
    load_abc();
    set_cmd(2'b01, 1);
    set_cmd(2'b10, 1);
    exp_q.push_back(sha1_model(HInit));
    send_words(0, 15, 0, e0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abc_load_timeout got=0 exp=1"); end
    wait_done(e0, 1'b0, lat, nd, jt);
    checks++; if (lat !== 81) begin failures++; $display("FAIL abc_latency got=%0d exp=81", lat); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL abc_done_count got=%0d exp=1", nd); end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (digest !== exp_d) begin failures++; $display("FAIL abc_model got=%h exp=%h", digest, exp_d); end
    checks++; if (digest !== Abc) begin failures++; $display("FAIL abc_digest got=%h exp=%h", digest, Abc); end
    checks++; if (digest_valid !== 1'b1) begin failures++; $display("FAIL abc_dval got=%b exp=1", digest_valid); end
  endtask

  task automatic test_empty();
    int e0, lat, nd, jt;
    bit ok;
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h80000000;
    set_cmd(2'b01, 1);
    set_cmd(2'b10, 1);
    exp_q.push_back(sha1_model(HInit));
    send_words(0, 15, 0, e0, ok);
    wait_done(e0, 1'b0, lat, nd, jt);
    checks++; if (lat !== 81) begin failures++; $display("FAIL empty_latency got=%0d exp=81", lat); end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (digest !== exp_d) begin failures++; $display("FAIL empty_model got=%h exp=%h", digest, exp_d); end
    checks++; if (digest !== Empty) begin failures++; $display("FAIL empty_digest got=%h exp=%h", digest, Empty); end
  endtask

  task automatic test_two_block();
    int e0, lat, nd, jt;
    bit ok;
    logic [159:0] mh;
    logic [31:0] b1 [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                             32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                             32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                             32'h6d6e6f70, 32'h6e6f7071};
    for (int i = 0; i < 14; i++) blk[i] = b1[i];
    blk[14] = 32'h80000000;
    blk[15] = 32'h00000000;
    mh = sha1_model(HInit);
    exp_q.push_back(mh);
    set_cmd(2'b01, 1);
    set_cmd(2'b10, 1);
    send_words(0, 15, 30, e0, ok);
    wait_done(e0, 1'b1, lat, nd, jt);
    checks++; if (nd !== 1) begin failures++; $display("FAIL blk1_done_count got=%0d exp=1", nd); end
    checks++; if (jt !== 0) begin failures++; $display("FAIL blk1_junk_taken got=%0d exp=0", jt); end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (digest !== exp_d) begin failures++; $display("FAIL blk1_model got=%h exp=%h", digest, exp_d); end

    for (int i = 0; i < 15; i++) blk[i] = '0;
    blk[15] = 32'h000001c0;
    exp_q.push_back(sha1_model(mh));
    send_words(0, 0, 30, e0, ok);
    @(negedge clk);
    msg_valid = 1'b0;
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL blk2_dval_clear got=%b exp=0", digest_valid); end
    send_words(1, 15, 30, e0, ok);
    wait_done(e0, 1'b1, lat, nd, jt);
    checks++; if (nd !== 1) begin failures++; $display("FAIL blk2_done_count got=%0d exp=1", nd); end
    checks++; if (jt !== 0) begin failures++; $display("FAIL blk2_junk_taken got=%0d exp=0", jt); end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (digest !== exp_d) begin failures++; $display("FAIL blk2_model got=%h exp=%h", digest, exp_d); end
    checks++; if (digest !== TwoBlk) begin failures++; $display("FAIL two_block_digest got=%h exp=%h", digest, TwoBlk); end
  endtask

  task automatic test_abort();
    int e0, lat, nd, jt, n;
    bit ok;
    load_abc();
    set_cmd(2'b01, 1);
    set_cmd(2'b10, 1);
    send_words(0, 15, 0, e0, ok);
    n = 0;
    while (cyc < e0 + 40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    state_in = 2'b01;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy_after got=%b exp=0", busy); end
    checks++; if (digest !== HInit) begin failures++; $display("FAIL abort_digest got=%h exp=%h", digest, HInit); end
    nd = (done === 1'b1) ? 1 : 0;
    repeat (100) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin failures++; $display("FAIL abort_done_count got=%0d exp=0", nd); end
    set_cmd(2'b10, 1);
    exp_q.push_back(sha1_model(HInit));
    send_words(0, 15, 0, e0, ok);
    wait_done(e0, 1'b0, lat, nd, jt);
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (digest !== exp_d) begin failures++; $display("FAIL abort_rerun_model got=%h exp=%h", digest, exp_d); end
    checks++; if (digest !== Abc) begin failures++; $display("FAIL abort_rerun_digest got=%h exp=%h", digest, Abc); end
  endtask

  task automatic test_cmd11();
    int e0, lat, nd, jt;
    bit ok;
    load_abc();
    set_cmd(2'b01, 1);
    set_cmd(2'b10, 1);
    send_words(0, 6, 0, e0, ok);
    set_cmd(2'b11, 1);
    @(negedge clk);
    checks++; if (digest !== '0) begin failures++; $display("FAIL cmd11_digest got=%h exp=0", digest); end
    checks++; if (msg_ready !== 1'b0) begin failures++; $display("FAIL cmd11_ready got=%b exp=0", msg_ready); end
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL cmd11_dval got=%b exp=0", digest_valid); end
    set_cmd(2'b01, 1);
    set_cmd(2'b10, 1);
    exp_q.push_back(sha1_model(HInit));
    send_words(0, 15, 0, e0, ok);
    wait_done(e0, 1'b0, lat, nd, jt);
    checks++; if (nd !== 1) begin failures++; $display("FAIL cmd11_done_count got=%0d exp=1", nd); end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (digest !== exp_d) begin failures++; $display("FAIL cmd11_model got=%h exp=%h", digest, exp_d); end
    checks++; if (digest !== Abc) begin failures++; $display("FAIL cmd11_restart_digest got=%h exp=%h", digest, Abc); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_abc();
    test_empty();
    test_two_block();
    test_abort();
    test_cmd11();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
